// File: rtl/avr_cpu_stack_ctrl_if.sv
// Request/grant handshakes between the decoder/interrupt logic and the stack
// controller, plus the strobe/data bus from the controller to the return stack.
interface avr_cpu_stack_ctrl_if #(
    parameter int DATA_WIDTH = 9
);
    logic                  call_req;
    logic [DATA_WIDTH-1:0] call_addr;
    logic                  call_ack;
    logic                  irq_req;
    logic [DATA_WIDTH-1:0] irq_addr;
    logic                  irq_ack;
    logic                  ret_req;
    logic                  reti;
    logic                  ret_ack;
    logic                  ret_valid;
    logic [DATA_WIDTH-1:0] ret_addr;
    logic                  ret_was_reti;
    logic                  stk_rst;
    logic                  stk_read;
    logic                  stk_write;
    logic [DATA_WIDTH-1:0] stk_wdata;
    logic [DATA_WIDTH-1:0] stk_rdata;

    modport master (
        output call_req, call_addr, irq_req, irq_addr, ret_req, reti, stk_rdata,
        input  call_ack, irq_ack, ret_ack, ret_valid, ret_addr, ret_was_reti,
               stk_rst, stk_read, stk_write, stk_wdata
    );

    modport slave (
        input  call_req, call_addr, irq_req, irq_addr, ret_req, reti, stk_rdata,
        output call_ack, irq_ack, ret_ack, ret_valid, ret_addr, ret_was_reti,
               stk_rst, stk_read, stk_write, stk_wdata
    );
endinterface

// File: rtl/avr_cpu_stack_ctrl.sv
// Arbitrates CALL/IRQ pushes and RET/RETI pops onto the hardware return stack,
// tracks depth and sticky overflow/underflow, and respects the stack's TOS latency.
module avr_cpu_stack_ctrl #(
    parameter int DATA_WIDTH  = 9,
    parameter int STACK_DEPTH = 3,
    parameter int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   err_clr,
    avr_cpu_stack_ctrl_if.slave    bus,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf,
    output logic                   unf
);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_WIDTH-1:0]  depth_q, depth_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    ret_valid_q, ret_valid_d;
    logic [DATA_WIDTH-1:0]   ret_addr_q, ret_addr_d;
    logic                    ret_reti_q, ret_reti_d;

    logic                    call_ack, irq_ack, ret_ack;
    logic                    rd_en, wr_en;
    logic                    do_push, do_pop;
    logic                    ovf_set, unf_set;
    logic [DATA_WIDTH-1:0]   push_addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    is_full, is_empty;

    assign is_full  = (depth_q == DEPTH_WIDTH'(STACK_DEPTH));
    assign is_empty = (depth_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_addr_q  <= '0;
            ret_reti_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            ret_valid_q <= ret_valid_d;
            ret_addr_q  <= ret_addr_d;
            ret_reti_q  <= ret_reti_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        ret_valid_d = 1'b0;
        ret_addr_d  = ret_addr_q;
        ret_reti_d  = ret_reti_q;
        call_ack    = 1'b0;
        irq_ack     = 1'b0;
        ret_ack     = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        wdata       = '0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        push_addr   = '0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        // Grants are suppressed while held in reset; flush consumes the cycle without an ack.
        if (rst) begin
            if (flush) begin
                depth_d = '0;
            end else if (bus.irq_req) begin
                irq_ack   = 1'b1;
                do_push   = 1'b1;
                push_addr = bus.irq_addr;
            end else if (bus.ret_req && state_q == IDLE) begin
                ret_ack = 1'b1;
                do_pop  = 1'b1;
            end else if (bus.call_req) begin
                call_ack  = 1'b1;
                do_push   = 1'b1;
                push_addr = bus.call_addr;
            end
        end

        if (do_push) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                wdata   = push_addr;
                depth_d = depth_q + DEPTH_WIDTH'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end

        if (do_pop) begin
            ret_valid_d = 1'b1;
            ret_reti_d  = bus.reti;
            if (!is_empty) begin
                rd_en      = 1'b1;
                ret_addr_d = bus.stk_rdata;
                depth_d    = depth_q - DEPTH_WIDTH'(1);
            end else begin
                ret_addr_d = '0;
                unf_set    = 1'b1;
            end
        end

        // Any real stack access (or flush) leaves the TOS stale for one cycle.
        state_d = (flush || rd_en || wr_en) ? SETTLE : IDLE;

        ovf_d = ovf_set | (ovf_q & ~err_clr);
        unf_d = unf_set | (unf_q & ~err_clr);
    end

    assign bus.call_ack     = call_ack;
    assign bus.irq_ack      = irq_ack;
    assign bus.ret_ack      = ret_ack;
    assign bus.stk_read     = rd_en;
    assign bus.stk_write    = wr_en;
    assign bus.stk_wdata    = wdata;
    assign bus.stk_rst      = flush | ~rst;
    assign bus.ret_valid    = ret_valid_q;
    assign bus.ret_addr     = ret_addr_q;
    assign bus.ret_was_reti = ret_reti_q;

    assign depth = depth_q;
    assign full  = is_full;
    assign empty = is_empty;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_avr_cpu_stack_ctrl.sv
// Bench for avr_cpu_stack_ctrl: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based model of the stack controller.
module tb_avr_cpu_stack_ctrl;
    localparam int DW  = 9;
    localparam int SD  = 3;
    localparam int DPW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic err_clr = 1'b0;
    logic [DPW-1:0] depth;
    logic full, empty, ovf, unf;

    avr_cpu_stack_ctrl_if #(.DATA_WIDTH(DW)) bus();

    avr_cpu_stack_ctrl #(.DATA_WIDTH(DW), .STACK_DEPTH(SD), .DEPTH_WIDTH(DPW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr), .bus(bus),
        .depth(depth), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Return-stack stand-in: its TOS output refreshes one cycle after each change.
    logic [DW-1:0] env_mem [4];
    logic [1:0]    env_cnt = '0;
    logic [DW-1:0] env_tos = '0;
    assign bus.stk_rdata = env_tos;

    always @(posedge clk) begin
        env_tos <= (env_cnt != 2'd0) ? env_mem[env_cnt - 2'd1] : '0;
        if (bus.stk_rst) env_cnt <= '0;
        else if (bus.stk_write && env_cnt < 2'd3) begin
            env_mem[env_cnt] <= bus.stk_wdata;
            env_cnt <= env_cnt + 2'd1;
        end else if (bus.stk_read && env_cnt != 2'd0) env_cnt <= env_cnt - 2'd1;
    end

    // Reference model state
    logic [DW-1:0] m_q[$];
    bit            m_busy, m_rv, m_rr, m_ovf, m_unf;
    logic [DW-1:0] m_ra;

    bit o_call, o_irq, o_ret, o_rd, o_wr, o_rst;
    int n_err = 0;
    int n_chk = 0;
    logic [DW-1:0] exp_a [3];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_rv = 0; m_rr = 0; m_ovf = 0; m_unf = 0; m_ra = '0;
    endtask

    // One clock: called at a falling edge with inputs already applied.
    task automatic step();
        bit e_call = 0, e_irq = 0, e_ret = 0, e_rd = 0, e_wr = 0;
        bit push = 0, pop = 0, oset = 0, uset = 0;
        logic [DW-1:0] paddr = '0;
        #1;
        if (rst && !flush) begin
            if (bus.irq_req) begin e_irq = 1; push = 1; paddr = bus.irq_addr; end
            else if (bus.ret_req && !m_busy) begin e_ret = 1; pop = 1; end
            else if (bus.call_req) begin e_call = 1; push = 1; paddr = bus.call_addr; end
        end
        if (push) begin
            if (m_q.size() < SD) e_wr = 1;
            else oset = 1;
        end
        if (pop) e_rd = (m_q.size() > 0);

        o_call = bus.call_ack; o_irq = bus.irq_ack; o_ret = bus.ret_ack;
        o_rd = bus.stk_read; o_wr = bus.stk_write; o_rst = bus.stk_rst;
        chk("call_ack", int'(o_call), int'(e_call));
        chk("irq_ack", int'(o_irq), int'(e_irq));
        chk("ret_ack", int'(o_ret), int'(e_ret));
        chk("stk_read", int'(o_rd), int'(e_rd));
        chk("stk_write", int'(o_wr), int'(e_wr));
        chk("stk_rst", int'(o_rst), int'(flush | !rst));
        if (e_wr) chk("stk_wdata", int'(bus.stk_wdata), int'(paddr));

        if (!rst) model_reset();
        else begin
            m_rv = pop;
            if (flush) m_q.delete();
            if (e_wr) m_q.push_back(paddr);
            if (pop) begin
                m_rr = bus.reti;
                if (e_rd) m_ra = m_q.pop_back();
                else begin m_ra = '0; uset = 1; end
            end
            m_ovf = oset | (m_ovf & !err_clr);
            m_unf = uset | (m_unf & !err_clr);
            m_busy = flush | e_rd | e_wr;
        end

        @(negedge clk);
        chk("ret_valid", int'(bus.ret_valid), int'(m_rv));
        chk("ret_addr", int'(bus.ret_addr), int'(m_ra));
        chk("ret_was_reti", int'(bus.ret_was_reti), int'(m_rr));
        chk("depth", int'(depth), m_q.size());
        chk("full", int'(full), int'(m_q.size() == SD));
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("unf", int'(unf), int'(m_unf));
    endtask

    task automatic push_one(input logic [DW-1:0] a);
        bit done = 0;
        bus.call_req = 1'b1; bus.call_addr = a;
        for (int i = 0; i < 4 && !done; i++) begin step(); done = o_call; end
        bus.call_req = 1'b0;
        chk("push_grant", int'(done), 1);
    endtask

    task automatic pop_one(output logic [DW-1:0] a);
        bit done = 0;
        bus.ret_req = 1'b1;
        for (int i = 0; i < 4 && !done; i++) begin step(); done = o_ret; end
        bus.ret_req = 1'b0;
        chk("pop_grant", int'(done), 1);
        chk("pop_valid", int'(bus.ret_valid), 1);
        a = bus.ret_addr;
    endtask

    task automatic do_flush();
        flush = 1'b1; step(); flush = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] a;
        int k;
        bus.call_req = 0; bus.call_addr = '0; bus.irq_req = 0; bus.irq_addr = '0;
        bus.ret_req = 0; bus.reti = 0;
        model_reset();
        exp_a[0] = 9'h030; exp_a[1] = 9'h020; exp_a[2] = 9'h010;

        // Reset: requests present but nothing may be granted
        @(negedge clk);
        bus.call_req = 1'b1; bus.call_addr = 9'h1FF;
        step();
        chk("rst_stk_rst", int'(o_rst), 1);
        chk("rst_call_ack", int'(o_call), 0);
        bus.call_req = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Three back-to-back pushes, then drain with RET/RETI alternation
        bus.call_req = 1'b1;
        bus.call_addr = 9'h010; step(); chk("A_ack0", int'(o_call), 1);
        bus.call_addr = 9'h020; step(); chk("A_ack1", int'(o_call), 1);
        bus.call_addr = 9'h030; step(); chk("A_ack2", int'(o_call), 1);
        bus.call_req = 1'b0;
        chk("A_depth", int'(depth), 3);
        chk("A_full", int'(full), 1);
        chk("A_ovf", int'(ovf), 0);
        bus.ret_req = 1'b1; bus.reti = 1'b0; k = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("A_ret_cadence", int'(o_ret), i % 2);
            if (o_ret) bus.reti = ~bus.reti;
            if (bus.ret_valid && k < 3) begin
                chk("A_ret_addr", int'(bus.ret_addr), int'(exp_a[k]));
                k++;
            end
        end
        bus.ret_req = 1'b0;
        chk("A_pops", k, 3);
        chk("A_empty", int'(empty), 1);

        // Overflow: push into a full stack, then clear the flag
        push_one(9'h010); push_one(9'h020); push_one(9'h030);
        push_one(9'h0AA);
        chk("B_ovf_write", int'(o_wr), 0);
        chk("B_ovf", int'(ovf), 1);
        pop_one(a);
        chk("B_pop", int'(a), 9'h030);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("B_ovf_clr", int'(ovf), 0);
        do_flush();

        // Simultaneous irq/ret/call at depth 1 in IDLE
        push_one(9'h077);
        step();
        bus.irq_req = 1'b1; bus.irq_addr = 9'h055;
        bus.ret_req = 1'b1; bus.reti = 1'b0;
        bus.call_req = 1'b1; bus.call_addr = 9'h011;
        step(); chk("C_irq_first", int'(o_irq), 1); bus.irq_req = 1'b0;
        step(); chk("C_call_second", int'(o_call), 1); bus.call_req = 1'b0;
        step(); chk("C_ret_blocked", int'(o_ret), 0);
        step(); chk("C_ret_granted", int'(o_ret), 1); bus.ret_req = 1'b0;
        chk("C_ret_addr", int'(bus.ret_addr), 9'h011);
        do_flush();

        // Underflow: pop from empty
        pop_one(a);
        chk("D_read", int'(o_rd), 0);
        chk("D_addr", int'(a), 0);
        chk("D_unf", int'(unf), 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // Flush at depth 2 with a pending request, then push/pop round trip
        push_one(9'h101); push_one(9'h102);
        flush = 1'b1; bus.call_req = 1'b1; bus.call_addr = 9'h0EE;
        step();
        chk("E_no_ack", int'(o_call), 0);
        chk("E_stk_rst", int'(o_rst), 1);
        chk("E_depth", int'(depth), 0);
        flush = 1'b0; bus.call_req = 1'b0;
        push_one(9'h123);
        pop_one(a);
        chk("E_roundtrip", int'(a), 9'h123);

        // Asynchronous reset while a pop result is in flight
        push_one(9'h0AB);
        pop_one(a);
        #2 rst = 1'b0;
        #1;
        chk("F_ret_valid", int'(bus.ret_valid), 0);
        chk("F_depth", int'(depth), 0);
        chk("F_stk_rst", int'(bus.stk_rst), 1);
        chk("F_ret_addr", int'(bus.ret_addr), 0);
        model_reset();
        @(negedge clk);
        step();
        rst = 1'b1;
        step();

        // Randomized traffic with hold-until-ack requesters
        o_call = 0; o_irq = 0; o_ret = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!bus.call_req || o_call) begin
                bus.call_req = ($urandom_range(0, 2) == 0);
                bus.call_addr = DW'($urandom);
            end
            if (!bus.irq_req || o_irq) begin
                bus.irq_req = ($urandom_range(0, 7) == 0);
                bus.irq_addr = DW'($urandom);
            end
            if (!bus.ret_req || o_ret) begin
                bus.ret_req = ($urandom_range(0, 2) == 0);
                bus.reti = 1'($urandom);
            end
            flush = ($urandom_range(0, 39) == 0);
            err_clr = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
